modulo_n_updown_counter: RTL and testbench
==========================================

Name: modulo_n_updown_counter

Overview:
- Parametrised successor to the team's fixed decade counter.
- Counts modulo MODULUS (any value 2..2^WIDTH) up or down, with synchronous enable, parallel load, synchronous clear and terminal-count/carry outputs.
- Multiple instances chain through carry_out -> enable to form multi-digit BCD or mixed-radix counters (clocks, timers, frequency dividers) in the counters library.

Parameters:
- WIDTH, 4, bit width of the count output.
- MODULUS, 10, count sequence length. Valid range is 2..2^WIDTH. An illegal value causes an elaboration-time error.
- RESET_VALUE, 0, value loaded into count on reset and on synchronous clear. Must be below MODULUS.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear to RESET_VALUE; highest synchronous priority.
- load  input  1  synchronous parallel load of load_val.
- load_val  input  WIDTH  value to load.
- en  input  1  count enable; cascade input.
- up  input  1  direction: 1 = increment, 0 = decrement.
- out  output  WIDTH  registered count value.
- tc  output  1  combinational terminal count: out==MODULUS-1 when up=1, out==0 when up=0.
- carry_out  output  1  tc & en; single-cycle cascade pulse to the next stage's en.
- wrapped  output  1  registered flag, high for the one cycle after a wrap occurs.
- load_err  output  1  registered flag, high for the one cycle after a load with load_val >= MODULUS.

Behaviour:
- Reset, asynchronous (rstn=0): out=RESET_VALUE, wrapped=0, load_err=0, taking effect immediately regardless of clk.
  - tc and carry_out follow combinationally from out, up and en.
- Synchronous priority per rising edge: clr > load > en > hold.
- clr=1: out<=RESET_VALUE, wrapped<=0, load_err<=0.
- load=1 (clr=0):
  - If load_val<MODULUS: out<=load_val, load_err<=0.
  - Otherwise: out<=load_val mod MODULUS, load_err<=1.
  - wrapped<=0. en is ignored this cycle.
- en=1, up=1: out<=out+1. If out==MODULUS-1, out<=0 and wrapped<=1.
- en=1, up=0: out<=out-1. If out==0, out<=MODULUS-1 and wrapped<=1.
- en=0: out holds; wrapped<=0; load_err<=0.
- Latency: one cycle from an en/clr/load edge to the updated out. carry_out has zero latency (combinational on en).
- Arithmetic is done at WIDTH+1 bits internally so that MODULUS=2^WIDTH wraps correctly with no overflow aliasing.
- Direction change mid-count takes effect on the same edge. There is no extra state.
- Out-of-range state (out>=MODULUS) is unreachable after reset. If it is forced, the next enabled count goes to 0 (up) or MODULUS-1 (down).
- Reset asserted mid-count overrides everything asynchronously. Counting resumes on the first enabled edge after rstn deasserts.
- Cascade rule: stage k+1 en = stage k carry_out. The chain advances once per full cycle of stage k, and no glitches are introduced on registered outputs.

Test Plan:
- Reset and up count: MODULUS=10, rstn low 10ns then high, en=1, up=1, 12 clocks -> out 0,1,…,9,0,1. wrapped high only the cycle after 9->0. carry_out high only while out=9.
- Down count: en=1, up=0 from 0 -> out 9,8,…,0,9. tc high at out=0. wrapped asserts after 0->9.
- Load and priority:
  - load_val=7, load=1, en=1 -> out=7 the next cycle (en ignored).
  - clr=1 with load=1 -> out=0.
  - load_val=12 -> out=2, load_err=1 for one cycle.
- Async reset mid-count: assert rstn=0 between clock edges at out=5 -> out=0 immediately, with no clock edge needed. Hold en=0 for 3 cycles -> out stays constant.
- Power-of-two modulus: WIDTH=4, MODULUS=16, up count from 15 -> out=0, wrapped=1, no X or overflow. Down count from 0 -> 15.
- Two-stage cascade (MODULUS=10 each, en tied high on stage 0): after 100 clocks {stage1,stage0}=0,0 and stage1 has stepped 0..9 once. At 99 -> 00, both stages assert wrapped on the same cycle.

Source files
------------

// File: rtl/modulo_n_updown_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | modulo_n_updown_counter                                                  |
// | Modulo-MODULUS up/down counter: clear, load, enable, tc and carry chain. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module modulo_n_updown_counter #(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 10,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             carry_out,
  output logic             wrapped,
  output logic             load_err
);

  localparam logic [WIDTH:0]   c_MOD  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   c_LAST = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] c_RST  = WIDTH'(RESET_VALUE);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("modulo_n_updown_counter: MODULUS must lie in 2..2**WIDTH");
  end
  if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset_value
    $error("modulo_n_updown_counter: RESET_VALUE must be below MODULUS");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_wrapped;
  logic             r_load_err;

  logic [WIDTH:0]   w_cnt_ext;
  logic [WIDTH:0]   w_inc_ext;
  logic [WIDTH:0]   w_dec_ext;
  logic             w_up_wrap;
  logic             w_dn_wrap;
  logic [WIDTH:0]   w_load_ext;
  logic             w_load_err;
  logic [WIDTH-1:0] w_load_mod;

  // Extra headroom bit: any result at or beyond MODULUS (including an
  // underflow from 0, or a forced out-of-range count) is a wrap.
  assign w_cnt_ext  = {1'b0, r_count};
  assign w_inc_ext  = w_cnt_ext + 1'b1;
  assign w_dec_ext  = w_cnt_ext - 1'b1;
  assign w_up_wrap  = (w_inc_ext >= c_MOD);
  assign w_dn_wrap  = (w_dec_ext >= c_MOD);

  assign w_load_ext = {1'b0, load_val};
  assign w_load_err = (w_load_ext >= c_MOD);

  if (MODULUS == (1 << WIDTH)) begin : g_load_full_range
    assign w_load_mod = load_val;
  end else begin : g_load_reduce
    localparam logic [WIDTH-1:0] c_MOD_W = WIDTH'(MODULUS);
    assign w_load_mod = load_val % c_MOD_W;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count    <= c_RST;
      r_wrapped  <= 1'b0;
      r_load_err <= 1'b0;
    end else if (clr) begin
      r_count    <= c_RST;
      r_wrapped  <= 1'b0;
      r_load_err <= 1'b0;
    end else if (load) begin
      r_count    <= w_load_mod;
      r_wrapped  <= 1'b0;
      r_load_err <= w_load_err;
    end else if (en) begin
      r_load_err <= 1'b0;
      if (up) begin
        r_count   <= w_up_wrap ? '0 : w_inc_ext[WIDTH-1:0];
        r_wrapped <= w_up_wrap;
      end else begin
        r_count   <= w_dn_wrap ? c_LAST[WIDTH-1:0] : w_dec_ext[WIDTH-1:0];
        r_wrapped <= w_dn_wrap;
      end
    end else begin
      r_wrapped  <= 1'b0;
      r_load_err <= 1'b0;
    end
  end

  assign out       = r_count;
  assign tc        = up ? (w_cnt_ext == c_LAST) : (r_count == '0);
  assign carry_out = tc & en;
  assign wrapped   = r_wrapped;
  assign load_err  = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_modulo_n_updown_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_modulo_n_updown_counter                                               |
// | Self-checking bench: decimal, power-of-two and two-stage cascade counters.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_modulo_n_updown_counter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  bit chk_on   = 1'b0;

  // Instance A: decimal counter
  logic       a_clr = 0, a_load = 0, a_en = 0, a_up = 1;
  logic [3:0] a_lv = 0;
  logic [3:0] a_out;
  logic       a_tc, a_co, a_wr, a_le;
  // Instance B: full-range modulus 16
  logic       b_clr = 0, b_load = 0, b_en = 0, b_up = 1;
  logic [3:0] b_lv = 0;
  logic [3:0] b_out;
  logic       b_tc, b_co, b_wr, b_le;
  // Cascade C0 -> C1
  logic       c_en = 0;
  logic [3:0] c0_out, c1_out;
  logic       c0_tc, c0_co, c0_wr, c0_le, c1_tc, c1_co, c1_wr, c1_le;

  modulo_n_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_a (
    .clk(clk), .rstn(rstn), .clr(a_clr), .load(a_load), .load_val(a_lv),
    .en(a_en), .up(a_up), .out(a_out), .tc(a_tc), .carry_out(a_co),
    .wrapped(a_wr), .load_err(a_le));

  modulo_n_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) u_b (
    .clk(clk), .rstn(rstn), .clr(b_clr), .load(b_load), .load_val(b_lv),
    .en(b_en), .up(b_up), .out(b_out), .tc(b_tc), .carry_out(b_co),
    .wrapped(b_wr), .load_err(b_le));

  modulo_n_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_c0 (
    .clk(clk), .rstn(rstn), .clr(1'b0), .load(1'b0), .load_val(4'd0),
    .en(c_en), .up(1'b1), .out(c0_out), .tc(c0_tc), .carry_out(c0_co),
    .wrapped(c0_wr), .load_err(c0_le));

  modulo_n_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_c1 (
    .clk(clk), .rstn(rstn), .clr(1'b0), .load(1'b0), .load_val(4'd0),
    .en(c0_co), .up(1'b1), .out(c1_out), .tc(c1_tc), .carry_out(c1_co),
    .wrapped(c1_wr), .load_err(c1_le));

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one counter step in plain modular arithmetic.
  function automatic void mstep(input int m, input int rv, input int cur,
                                input bit clr, input bit ld, input int lv,
                                input bit en, input bit up,
                                output int nxt, output bit w, output bit le);
    nxt = cur; w = 0; le = 0;
    if (clr) nxt = rv;
    else if (ld) begin
      nxt = lv % m;
      le  = (lv >= m);
    end else if (en) begin
      if (up) begin w = (cur == m - 1); nxt = (cur + 1) % m; end
      else    begin w = (cur == 0);     nxt = (cur + m - 1) % m; end
    end
  endfunction

  int ma, mb, mc0, mc1;
  bit wa, lea, wb, leb, wc0, lec0, wc1, lec1;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ma = 0; mb = 0; mc0 = 0; mc1 = 0;
      {wa, lea, wb, leb, wc0, lec0, wc1, lec1} = '0;
    end else begin
      int n0, n1;
      bit m_carry0;
      m_carry0 = c_en && (mc0 == 9);
      mstep(10, 0, ma, a_clr, a_load, int'(a_lv), a_en, a_up, ma, wa, lea);
      mstep(16, 0, mb, b_clr, b_load, int'(b_lv), b_en, b_up, mb, wb, leb);
      mstep(10, 0, mc0, 0, 0, 0, c_en, 1, n0, wc0, lec0);
      mstep(10, 0, mc1, 0, 0, 0, m_carry0, 1, n1, wc1, lec1);
      mc0 = n0; mc1 = n1;
    end
  end

  always @(negedge clk) begin
    if (chk_on && rstn) begin
      bit t;
      t = a_up ? (ma == 9) : (ma == 0);
      chk("A.out", a_out, ma);      chk("A.tc", a_tc, t);
      chk("A.carry", a_co, t && a_en);
      chk("A.wrapped", a_wr, wa);   chk("A.load_err", a_le, lea);
      t = b_up ? (mb == 15) : (mb == 0);
      chk("B.out", b_out, mb);      chk("B.tc", b_tc, t);
      chk("B.carry", b_co, t && b_en);
      chk("B.wrapped", b_wr, wb);   chk("B.load_err", b_le, leb);
      chk("C0.out", c0_out, mc0);   chk("C0.carry", c0_co, c_en && mc0 == 9);
      chk("C0.wrapped", c0_wr, wc0);
      chk("C1.out", c1_out, mc1);   chk("C1.tc", c1_tc, mc1 == 9);
      chk("C1.carry", c1_co, (mc1 == 9) && c_en && (mc0 == 9));
      chk("C1.wrapped", c1_wr, wc1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("reset.out", a_out, 0);
    chk("reset.wrapped", a_wr, 0);
    chk("reset.load_err", a_le, 0);
    rstn = 1'b1;
    chk_on = 1'b1;
    tick();

    // Up count 0..9,0,1
    a_en = 1; a_up = 1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 9)  chk("up.carry_at_9", a_co, 1);
      if (i == 10) begin chk("up.wrap_out", a_out, 0); chk("up.wrapped", a_wr, 1); end
      if (i == 11) begin chk("up.after_wrap", a_out, 1); chk("up.wrapped_drop", a_wr, 0); end
    end

    // Down count from 0
    a_clr = 1; tick(); a_clr = 0;
    chk("clr.out", a_out, 0);
    a_up = 0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (i == 1)  begin chk("down.wrap_out", a_out, 9); chk("down.wrapped", a_wr, 1); end
      if (i == 10) begin chk("down.at_0", a_out, 0); chk("down.tc", a_tc, 1); end
    end

    // Load and priority
    a_load = 1; a_lv = 4'd7; a_en = 1;
    tick(); chk("load.7", a_out, 7); chk("load.err_low", a_le, 0);
    a_clr = 1;
    tick(); chk("clr_over_load", a_out, 0);
    a_clr = 0; a_lv = 4'd12;
    tick(); chk("load.12_mod", a_out, 2); chk("load.err_high", a_le, 1);
    a_load = 0; a_en = 0;
    tick(); chk("hold.out", a_out, 2); chk("load.err_pulse", a_le, 0);

    // Async reset mid-count at 5
    a_en = 1; a_up = 1;
    tick(); tick(); tick();
    chk("count_to_5", a_out, 5);
    #3 rstn = 1'b0;
    #1 chk("async_reset", a_out, 0);
    a_en = 0;
    #2 rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("hold_after_reset", a_out, 0);
    end

    // Full-range modulus 16
    b_load = 1; b_lv = 4'd15; b_up = 1;
    tick(); chk("b.load15", b_out, 15);
    b_load = 0; b_en = 1;
    tick(); chk("b.up_wrap", b_out, 0); chk("b.wrapped", b_wr, 1);
    b_up = 0;
    tick(); chk("b.down_wrap", b_out, 15); chk("b.wrapped_dn", b_wr, 1);
    b_en = 0;

    // Two-stage cascade, 100 clocks
    c_en = 1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i == 99) begin chk("casc.99_lo", c0_out, 9); chk("casc.99_hi", c1_out, 9); end
      if (i == 100) begin
        chk("casc.00_lo", c0_out, 0);  chk("casc.00_hi", c1_out, 0);
        chk("casc.wr_lo", c0_wr, 1);   chk("casc.wr_hi", c1_wr, 1);
      end
    end
    c_en = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
